// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the iterative binary-to-BCD converter.
// FSM encodings, BCD digit width, compile-time powers of ten and counter sizing.
package bcd_pkg;

  localparam int BCD_DIG_W = 4;

  typedef logic [0:0] state_t;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // 34 bits holds 10^9 and any zero-extended 32-bit input without truncation.
  function automatic logic [33:0] pow10(input int n);
    logic [33:0] r;
    r = 34'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 34'd10;
    end
    return r;
  endfunction

  function automatic int cnt_w(input int bin_w);
    return $clog2(bin_w) + 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIG_W-1:0] d,
  output logic [BCD_DIG_W-1:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_iter.sv
// Sequential binary-to-BCD converter: one bit per cycle shift-add-3, with saturation
// on overflow and leading-zero digit enables for the display path.
//
// Handshake: ready=1 only in IDLE; start is accepted on the rising edge where
// start && ready, and data is captured on that same edge. valid is a one-cycle
// pulse BIN_W cycles later; bcd/overflow/digit_en hold until the next pulse.
module bin2bcd_iter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      data,
  output logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int WORK_W = BCD_DIG_W * DIGITS;
  localparam int CNT_W  = cnt_w(BIN_W);
  localparam logic [33:0]       LIMIT  = pow10(DIGITS);
  localparam logic [WORK_W-1:0] NINES  = {DIGITS{4'd9}};

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [WORK_W-1:0]   bcd_q, bcd_d;
  logic                overflow_q, overflow_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                valid_q, valid_d;

  logic [WORK_W-1:0]   work_adj;
  logic [WORK_W-1:0]   work_nxt;
  logic [BIN_W-1:0]    shift_nxt;
  logic [33:0]         data_ext;
  logic [DIGITS-1:0]   en_fin;
  logic                seen_nz;
  logic                last_bit;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (work_q[BCD_DIG_W*g +: BCD_DIG_W]),
      .q (work_adj[BCD_DIG_W*g +: BCD_DIG_W])
    );
  end

  // Carries out of the top digit fall off here; the input compare flags them.
  assign work_nxt  = {work_adj[WORK_W-2:0], shift_q[BIN_W-1]};
  assign shift_nxt = shift_q << 1;
  assign data_ext  = 34'(data);
  assign last_bit  = (cnt_q == CNT_W'(BIN_W - 1));

  // A digit is significant if it or any more-significant digit is nonzero.
  always_comb begin
    seen_nz = 1'b0;
    en_fin  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen_nz   = seen_nz | (|work_nxt[BCD_DIG_W*i +: BCD_DIG_W]);
      en_fin[i] = seen_nz;
    end
    en_fin[0] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    digit_en_d = digit_en_q;
    valid_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d = data;
          work_d  = '0;
          cnt_d   = '0;
          ovf_d   = (data_ext >= LIMIT);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d  = work_nxt;
        shift_d = shift_nxt;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          bcd_d      = ovf_q ? NINES : work_nxt;
          overflow_d = ovf_q;
          digit_en_d = ovf_q ? {DIGITS{1'b1}} : en_fin;
          valid_d    = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      digit_en_q <= {{(DIGITS-1){1'b0}}, 1'b1};
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      digit_en_q <= digit_en_d;
      valid_q    <= valid_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign valid    = valid_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;
  assign digit_en = digit_en_q;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Directed and random stimulus for bin2bcd_iter with a decimal reference model and
// an expected-result queue popped on every valid pulse.
module tb_bin2bcd_iter;

  localparam int BIN_W  = 20;
  localparam int DIGITS = 6;
  localparam int BW     = 4 * DIGITS;

  typedef struct packed {
    logic [BW-1:0]     bcd;
    logic              ovf;
    logic [DIGITS-1:0] en;
    logic [31:0]       cyc;
  } exp_t;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              start   = 1'b0;
  logic [BIN_W-1:0]  data    = '0;
  logic              ready;
  logic              valid;
  logic [BW-1:0]     bcd;
  logic              overflow;
  logic [DIGITS-1:0] digit_en;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   vcount = 0;
  int   last_vcyc = 0;
  exp_t exp_q[$];

  bin2bcd_iter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .data     (data),
    .ready    (ready),
    .valid    (valid),
    .bcd      (bcd),
    .overflow (overflow),
    .digit_en (digit_en)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_model(input int unsigned v);
    exp_t r;
    int unsigned x;
    logic seen;
    r = '0;
    if (v > 999999) begin
      r.ovf = 1'b1;
      for (int i = 0; i < DIGITS; i++) r.bcd[4*i +: 4] = 4'd9;
      r.en = '1;
    end else begin
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
        r.bcd[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
      seen = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        if (r.bcd[4*i +: 4] != 4'd0) seen = 1'b1;
        r.en[i] = seen;
      end
      r.en[0] = 1'b1;
    end
    return r;
  endfunction

  // scoreboard: pop and compare on every valid pulse
  always @(negedge sys_clk) begin
    if (valid) begin
      exp_t e;
      vcount++;
      last_vcyc = cyc;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_valid observed=1 expected=0 at cycle %0d", cyc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("bcd", 64'(bcd), 64'(e.bcd));
        chk("overflow", 64'(overflow), 64'(e.ovf));
        chk("digit_en", 64'(digit_en), 64'(e.en));
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("ready_in_valid", 64'(ready), 64'd1);
      end
    end
  end

  // driver: wait for ready, present start for one edge, queue the expectation
  task automatic issue(input logic [BIN_W-1:0] d);
    exp_t e;
    int n;
    n = 0;
    @(negedge sys_clk);
    while (!ready && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
    start = 1'b1;
    data  = d;
    @(posedge sys_clk);
    #1;
    e = ref_model(32'(d));
    e.cyc = 32'(cyc + BIN_W);
    exp_q.push_back(e);
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    @(negedge sys_clk);
    chk("pending_results", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int v0, first_v, n;
    exp_t e;

    // reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_bcd", 64'(bcd), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_digit_en", 64'(digit_en), 64'd1);
    sys_rst = 1'b0;

    // full-width digits, small values, zero, overflow
    issue(20'd987360); wait_done();
    issue(20'd489);    wait_done();
    issue(20'd0);      wait_done();
    issue(20'd999999); wait_done();
    issue(20'd1000000); wait_done();
    issue(20'hFFFFF);  wait_done();

    // start/data changes during SHIFT are ignored
    v0 = vcount;
    issue(20'd125479);
    repeat (4) @(negedge sys_clk);
    start = 1'b1;
    data  = 20'd2874;
    @(negedge sys_clk);
    start = 1'b0;
    wait_done();
    repeat (25) @(negedge sys_clk);
    chk("ignored_start_vcount", 64'(vcount - v0), 64'd1);

    // back-to-back start in the valid cycle
    issue(20'd31415);
    n = 0;
    while (!valid && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    chk("b2b_first_valid", 64'(valid), 64'd1);
    first_v = cyc;
    start = 1'b1;
    data  = 20'd45162;
    @(posedge sys_clk);
    #1;
    e = ref_model(32'd45162);
    e.cyc = 32'(cyc + BIN_W);
    exp_q.push_back(e);
    @(negedge sys_clk);
    start = 1'b0;
    wait_done();
    chk("b2b_gap", 64'(last_vcyc - first_v), 64'd21);

    // reset mid-conversion aborts without a valid pulse
    v0 = vcount;
    @(negedge sys_clk);
    start = 1'b1;
    data  = 20'd777777;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (9) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    chk("abort_bcd", 64'(bcd), 64'd0);
    chk("abort_overflow", 64'(overflow), 64'd0);
    chk("abort_digit_en", 64'(digit_en), 64'd1);
    chk("abort_valid", 64'(valid), 64'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("abort_ready", 64'(ready), 64'd1);
    repeat (30) @(negedge sys_clk);
    chk("abort_no_valid", 64'(vcount - v0), 64'd0);

    // random sweep, biased toward the non-overflow range
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 7) == 0)
        issue(20'($urandom_range(0, 1048575)));
      else
        issue(20'($urandom_range(0, 999999)));
      if ($urandom_range(0, 3) == 0) wait_done();
    end
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    errors++;
    $display("FAIL global_timeout observed=cycle %0d expected=finish", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
